// File: rtl/stride_updown_counter.sv
// Up/down counter over the sequence BASE + idx*STEP, idx in [0, NSTEPS-1], with wrap/saturate ends.
// Optional feature: define STRIDE_CNT_SAT_EN to honour the `sat` input; otherwise the counter always wraps.
module stride_updown_counter #(
    parameter int WIDTH  = 4,
    parameter int BASE   = 1,
    parameter int STEP   = 2,
    parameter int NSTEPS = 8,
    localparam int IW    = ($clog2(NSTEPS) > 1) ? $clog2(NSTEPS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          up,
    input  logic          sat,
    input  logic          load,
    input  logic [IW-1:0] load_idx,
    output logic [WIDTH-1:0] count,
    output logic [IW-1:0] idx,
    output logic          at_end,
    output logic          wrapped
);

    localparam longint MAX_VAL = longint'(BASE) + longint'(NSTEPS - 1) * longint'(STEP);
    localparam logic [IW:0] LAST_EXT = (IW + 1)'(NSTEPS - 1);

    if (STEP < 1 || NSTEPS < 2 || MAX_VAL >= (longint'(1) << WIDTH)) begin : g_param_check
        $fatal(1, "stride_updown_counter: illegal STEP/NSTEPS/BASE/WIDTH combination");
    end

    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrapped_q, wrapped_d;
    logic             sat_mode;
    logic [IW:0]      idx_ext;
    logic [IW:0]      load_ext;

`ifdef STRIDE_CNT_SAT_EN
    assign sat_mode = sat;
`else
    logic unused_sat;
    assign unused_sat = sat;
    assign sat_mode   = 1'b0;
`endif

    assign idx_ext  = {1'b0, idx_q};
    assign load_ext = {1'b0, load_idx};
    assign at_end   = up ? (idx_ext == LAST_EXT) : (idx_ext == '0);

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        idx_d     = idx_q;
        wrapped_d = 1'b0;
        if (load) begin
            idx_d = (load_ext > LAST_EXT) ? IW'(LAST_EXT) : load_idx;
        end else if (en) begin
            if (!at_end) begin
                idx_d = up ? IW'(idx_ext + 1'b1) : IW'(idx_ext - 1'b1);
            end else if (!sat_mode) begin
                idx_d     = up ? '0 : IW'(LAST_EXT);
                wrapped_d = 1'b1;
            end
        end
    end

    // count follows the next index so it lands on the same edge as idx
    assign count_d = WIDTH'(longint'(BASE) + longint'(idx_d) * longint'(STEP));

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q     <= '0;
            count_q   <= WIDTH'(BASE);
            wrapped_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign idx     = idx_q;
    assign count   = count_q;
    assign wrapped = wrapped_q;

endmodule

// File: tb/tb_stride_updown_counter.sv
// Self-checking bench: default counter (8 steps, base 1, stride 2) and a 5-step variant (base 0, stride 3)
// driven by shared stimulus and compared every cycle against an index-level reference model.
module tb_stride_updown_counter;

    logic       clk = 1'b0;
    logic       reset, en, up, sat, load;
    logic [2:0] load_idx;
    logic [3:0] count_a, count_b;
    logic [2:0] idx_a, idx_b;
    logic       at_end_a, at_end_b, wrapped_a, wrapped_b;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  ma_idx, mb_idx;
    bit  ma_wr, mb_wr;

`ifdef STRIDE_CNT_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif

    stride_updown_counter u_dut_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
        .load_idx(load_idx), .count(count_a), .idx(idx_a), .at_end(at_end_a), .wrapped(wrapped_a)
    );

    stride_updown_counter #(.WIDTH(4), .BASE(0), .STEP(3), .NSTEPS(5)) u_dut_b (
        .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load),
        .load_idx(load_idx), .count(count_b), .idx(idx_b), .at_end(at_end_b), .wrapped(wrapped_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Next index of a counter with n positions, following load > en > hold.
    function automatic int model_next(input int n, input int cur, input bit l, input int li,
                                      input bit e, input bit u, input bit s, output bit wr);
        wr = 1'b0;
        if (l) return (li > n - 1) ? n - 1 : li;
        if (!e) return cur;
        if (u && cur < n - 1) return cur + 1;
        if (!u && cur > 0) return cur - 1;
        if (SAT_BUILD && s) return cur;
        wr = 1'b1;
        return u ? 0 : n - 1;
    endfunction

    function automatic int seq_val(input int base, input int step, input int i);
        return (base + i * step) % 16;
    endfunction

    task automatic compare_all();
        check("a_count",   count_a,   seq_val(1, 2, ma_idx));
        check("a_idx",     idx_a,     ma_idx);
        check("a_at_end",  at_end_a,  up ? (ma_idx == 7) : (ma_idx == 0));
        check("a_wrapped", wrapped_a, ma_wr);
        check("b_count",   count_b,   seq_val(0, 3, mb_idx));
        check("b_idx",     idx_b,     mb_idx);
        check("b_at_end",  at_end_b,  up ? (mb_idx == 4) : (mb_idx == 0));
        check("b_wrapped", wrapped_b, mb_wr);
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            ma_idx = model_next(8, ma_idx, load, load_idx, en, up, sat, ma_wr);
            mb_idx = model_next(5, mb_idx, load, load_idx, en, up, sat, mb_wr);
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b0; en = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0; load_idx = '0;
        ma_idx = 0; mb_idx = 0; ma_wr = 1'b0; mb_wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        compare_all();
        reset = 1'b1;
    endtask

    initial begin
        int exp_up_a[9] = '{3, 5, 7, 9, 11, 13, 15, 1, 3};
        int exp_up_b[5] = '{3, 6, 9, 12, 0};
        int exp_sat[3];
        if (SAT_BUILD) exp_sat = '{15, 15, 15};
        else           exp_sat = '{15, 1, 3};

        do_reset();
        check("rst_count_a", count_a, 1);
        check("rst_count_b", count_b, 0);

        // Full up sweep with wrap
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("up_seq_a", count_a, exp_up_a[i]);
            check("up_wrap_a", wrapped_a, (i == 7));
            if (i < 5) begin
                check("up_seq_b", count_b, exp_up_b[i]);
                check("up_wrap_b", wrapped_b, (i == 4));
            end
        end

        // Down from reset wraps immediately
        do_reset();
        en = 1'b1; up = 1'b0;
        tick();
        check("dn_count_a", count_a, 15);
        check("dn_wrap_a", wrapped_a, 1);
        check("dn_count_b", count_b, 12);
        tick();
        check("dn_count2_a", count_a, 13);
        check("dn_wrap2_a", wrapped_a, 0);
        check("dn_count2_b", count_b, 9);

        // Load beats enable; out-of-range index clamps on the 5-step counter
        load = 1'b1; load_idx = 3'd5; up = 1'b1;
        tick();
        check("ld5_count_a", count_a, 11);
        check("ld5_idx_a", idx_a, 5);
        check("ld5_wrap_a", wrapped_a, 0);
        check("ld5_idx_b", idx_b, 4);
        load_idx = 3'd7;
        tick();
        check("ld7_count_a", count_a, 15);
        check("ld7_count_b", count_b, 12);

        // Saturate vs wrap at the top end
        load_idx = 3'd6;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat_count_a", count_a, exp_sat[i]);
        end

        // Asynchronous reset mid-count
        do_reset();
        en = 1'b1; up = 1'b1;
        repeat (4) tick();
        check("pre_rst_count_a", count_a, 9);
        reset = 1'b0;
        ma_idx = 0; mb_idx = 0; ma_wr = 1'b0; mb_wr = 1'b0;
        #1;
        check("arst_count_a", count_a, 1);
        check("arst_idx_a", idx_a, 0);
        check("arst_wrap_a", wrapped_a, 0);
        check("arst_count_b", count_b, 0);
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic against the model
        repeat (400) begin
            en       = ($urandom_range(0, 3) != 0);
            up       = $urandom_range(0, 1);
            sat      = $urandom_range(0, 1);
            load     = ($urandom_range(0, 9) == 0);
            load_idx = 3'($urandom_range(0, 7));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
